// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the rx pin, validates the start bit, samples
// eight LSB-first data bits at mid-bit, checks the stop bit and strobes the byte out.
module uart_rx #(
   parameter int UART_BPS = 9600,
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rx,
   output logic [7:0] po_data,
   output logic       po_flag,
   output logic       po_err
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int HALF         = BAUD_CNT_MAX / 2;
   localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] C_SAMPLE = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] C_WRAP   = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic             r_rx1;
   logic             r_rx2;
   logic             r_rx3;
   logic             w_startEdge;

   logic [CNT_W-1:0] r_baudCnt;
   logic [3:0]       r_bitCnt;
   logic             w_sample;
   logic             w_wrap;

   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_flag;
   logic             r_err;
   logic             w_good;
   logic             w_bad;

   // r_rx1 is the metastability catcher; only r_rx2/r_rx3 feed the logic.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx1 <= 1'b1;
         r_rx2 <= 1'b1;
         r_rx3 <= 1'b1;
      end else begin
         r_rx1 <= rx;
         r_rx2 <= r_rx1;
         r_rx3 <= r_rx2;
      end
   end

   assign w_startEdge = r_rx3 & ~r_rx2;
   assign w_sample    = (r_baudCnt == C_SAMPLE);
   assign w_wrap      = (r_baudCnt == C_WRAP);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // STOP returns to IDLE at its mid-bit sample so a start bit that follows
   // immediately after a single stop bit is still caught.
   always_comb begin
      w_nextState = r_state;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_startEdge) begin
               w_nextState = START;
            end
         end
         START: begin
            if (w_sample && r_rx2) begin
               w_nextState = IDLE;
            end else if (w_wrap) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_wrap && (r_bitCnt == 4'd8)) begin
               w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_sample) begin
               w_nextState = IDLE;
               w_good      = r_rx2;
               w_bad       = ~r_rx2;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // bit_cnt counts completed bit periods: 1 after the start bit, 9 after data bit 7.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_baudCnt <= '0;
         r_bitCnt  <= 4'd0;
      end else if (r_state == IDLE) begin
         r_baudCnt <= '0;
         r_bitCnt  <= 4'd0;
      end else if (w_wrap) begin
         r_baudCnt <= '0;
         r_bitCnt  <= r_bitCnt + 4'd1;
      end else begin
         r_baudCnt <= r_baudCnt + C_ONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift <= 8'h00;
      end else if ((r_state == DATA) && w_sample) begin
         r_shift <= {r_rx2, r_shift[7:1]};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_data <= 8'h00;
         r_flag <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_flag <= w_good;
         r_err  <= w_bad;
         if (w_good) begin
            r_data <= r_shift;
         end
      end
   end

   assign po_data = r_data;
   assign po_flag = r_flag;
   assign po_err  = r_err;

endmodule
